// File: rtl/midi_tx_if.sv
// ============================================================================
// midi_tx_if : decoded MIDI command bus with serial-side status, plus command codes
// Revision   : 1.0
// ============================================================================
`default_nettype none

package midi_tx_pkg;
  localparam int MIDI_CMD_SIZE = 3;

  localparam logic [MIDI_CMD_SIZE-1:0] MIDI_CMD_NONE        = 3'd0;
  localparam logic [MIDI_CMD_SIZE-1:0] MIDI_CMD_NOTE_OFF    = 3'd1;
  localparam logic [MIDI_CMD_SIZE-1:0] MIDI_CMD_NOTE_ON     = 3'd2;
  localparam logic [MIDI_CMD_SIZE-1:0] MIDI_CMD_CTRL_CHANGE = 3'd3;
  localparam logic [MIDI_CMD_SIZE-1:0] MIDI_CMD_PROG_CHANGE = 3'd4;
  localparam logic [MIDI_CMD_SIZE-1:0] MIDI_CMD_PITCH_BEND  = 3'd5;
endpackage

interface midi_tx_if;
  logic                                  midi_rdy;
  logic [midi_tx_pkg::MIDI_CMD_SIZE-1:0] midi_cmd;
  logic [3:0]                            midi_ch_sysn;
  logic [6:0]                            midi_data0;
  logic [6:0]                            midi_data1;
  logic                                  midi_tx;
  logic                                  midi_busy;
  logic                                  midi_tx_done;
  logic                                  midi_drop;

  modport master (
    output midi_rdy, midi_cmd, midi_ch_sysn, midi_data0, midi_data1,
    input  midi_tx, midi_busy, midi_tx_done, midi_drop
  );

  modport slave (
    input  midi_rdy, midi_cmd, midi_ch_sysn, midi_data0, midi_data1,
    output midi_tx, midi_busy, midi_tx_done, midi_drop
  );
endinterface

`default_nettype wire

// File: rtl/midi_tx.sv
// ============================================================================
// midi_tx : rebuilds decoded MIDI commands into status/data bytes on a UART line
//           Optional running status: define MIDI_TX_RUNNING_STATUS_EN
// Revision: 1.0
// ============================================================================
`default_nettype none

module midi_tx #(
  parameter int BAUD_DIV = 3200
) (
  input  logic     clk,
  input  logic     reset,
  midi_tx_if.slave bus
);
  import midi_tx_pkg::*;

  localparam int            CW        = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [1:0]    byte_q, byte_d;
  logic [1:0]    len_q, len_d;
  logic [7:0]    status_q, status_d;
  logic [6:0]    data0_q, data0_d;
  logic [6:0]    data1_q, data1_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          drop_q, drop_d;

  logic          cmd_valid;
  logic          two_data;
  logic [3:0]    type_nib;
  logic [7:0]    new_status;
  logic          accept;
  logic          skip;
  logic          baud_end;
  logic [7:0]    cur_byte;

  always_comb begin
    cmd_valid = 1'b1;
    two_data  = 1'b1;
    type_nib  = 4'h0;
    case (bus.midi_cmd)
      MIDI_CMD_NOTE_OFF:    type_nib = 4'h8;
      MIDI_CMD_NOTE_ON:     type_nib = 4'h9;
      MIDI_CMD_CTRL_CHANGE: type_nib = 4'hB;
      MIDI_CMD_PROG_CHANGE: begin
        type_nib = 4'hC;
        two_data = 1'b0;
      end
      MIDI_CMD_PITCH_BEND:  type_nib = 4'hE;
      default:              cmd_valid = 1'b0;
    endcase
  end

  assign new_status = {type_nib, bus.midi_ch_sysn};
  assign accept     = bus.midi_rdy && cmd_valid && (state_q == S_IDLE);
  assign baud_end   = (baud_q == BAUD_LAST);

`ifdef MIDI_TX_RUNNING_STATUS_EN
  logic [7:0] last_status_q;

  assign skip = (new_status == last_status_q);

  always_ff @(posedge clk) begin
    if (!reset) begin
      last_status_q <= 8'h00;
    end else if (accept && !skip) begin
      last_status_q <= new_status;
    end
  end
`else
  assign skip = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= 3'd0;
      byte_q   <= 2'd0;
      len_q    <= 2'd0;
      status_q <= 8'h00;
      data0_q  <= 7'h00;
      data1_q  <= 7'h00;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      len_q    <= len_d;
      status_q <= status_d;
      data0_q  <= data0_d;
      data1_q  <= data1_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      drop_q   <= drop_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_end ? '0 : baud_q + CW'(1);
    bit_d    = bit_q;
    byte_d   = byte_q;
    len_d    = len_q;
    status_d = status_q;
    data0_d  = data0_q;
    data1_d  = data1_q;
    cur_byte = 8'hFF;

    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        bit_d  = 3'd0;
        if (accept) begin
          state_d  = S_START;
          byte_d   = skip ? 2'd1 : 2'd0;
          len_d    = two_data ? 2'd3 : 2'd2;
          status_d = new_status;
          data0_d  = bus.midi_data0;
          data1_d  = bus.midi_data1;
        end
      end
      S_START: begin
        if (baud_end) begin
          state_d = S_DATA;
          bit_d   = 3'd0;
        end
      end
      S_DATA: begin
        if (baud_end) begin
          if (bit_q == 3'd7) state_d = S_STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      S_STOP: begin
        // The next start bit follows the stop bit with no idle gap.
        if (baud_end) begin
          if ((byte_q + 2'd1) == len_q) begin
            state_d = S_IDLE;
            byte_d  = 2'd0;
          end else begin
            state_d = S_START;
            byte_d  = byte_q + 2'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    case (byte_d)
      2'd0:    cur_byte = status_q;
      2'd1:    cur_byte = {1'b0, data0_q};
      default: cur_byte = {1'b0, data1_q};
    endcase

    // Outputs are registered, so they are derived from the next-state values.
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = cur_byte[bit_d];
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_STOP) && (baud_d == BAUD_LAST) && ((byte_d + 2'd1) == len_d);
    drop_d = bus.midi_rdy && cmd_valid && (state_q != S_IDLE);
  end

  assign bus.midi_tx      = tx_q;
  assign bus.midi_busy    = busy_q;
  assign bus.midi_tx_done = done_q;
  assign bus.midi_drop    = drop_q;

endmodule

`default_nettype wire

// File: tb/tb_midi_tx.sv
// ============================================================================
// tb_midi_tx : directed self-checking bench for midi_tx at BAUD_DIV = 4
// Revision   : 1.0
// ============================================================================
`default_nettype none

module tb_midi_tx;
  import midi_tx_pkg::*;

  localparam int BD      = 4;
  localparam int FRAME   = 10 * BD;
  localparam int CAP_MAX = 256;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  midi_tx_if bus();

  midi_tx #(.BAUD_DIV(BD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic cap_tx   [CAP_MAX];
  logic cap_busy [CAP_MAX];
  logic cap_done [CAP_MAX];
  logic cap_drop [CAP_MAX];

  // Index 0 is the cycle right after the accepting edge of the last strobe.
  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      cap_tx[i]   = bus.midi_tx;
      cap_busy[i] = bus.midi_busy;
      cap_done[i] = bus.midi_tx_done;
      cap_drop[i] = bus.midi_drop;
      @(negedge clk);
    end
  endtask

  function automatic logic pick(input int sel, input int i);
    case (sel)
      0:       return cap_tx[i];
      1:       return cap_busy[i];
      2:       return cap_done[i];
      default: return cap_drop[i];
    endcase
  endfunction

  function automatic int count_hi(input int sel, input int lo, input int hi);
    int c = 0;
    for (int i = lo; i < hi; i++) if (pick(sel, i) === 1'b1) c++;
    return c;
  endfunction

  function automatic int first_hi(input int sel, input int lo, input int hi);
    for (int i = lo; i < hi; i++) if (pick(sel, i) === 1'b1) return i;
    return -1;
  endfunction

  function automatic logic [7:0] frame_byte(input int s);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[i] = cap_tx[s + (i + 1) * BD + BD / 2];
    return b;
  endfunction

  function automatic logic frame_ok(input int s);
    return (cap_tx[s + BD / 2] === 1'b0) && (cap_tx[s + 9 * BD + BD / 2] === 1'b1);
  endfunction

  task automatic set_cmd(input logic [MIDI_CMD_SIZE-1:0] cmd, input logic [3:0] ch,
                         input logic [6:0] d0, input logic [6:0] d1);
    bus.midi_cmd     = cmd;
    bus.midi_ch_sysn = ch;
    bus.midi_data0   = d0;
    bus.midi_data1   = d1;
  endtask

  task automatic strobe(input logic [MIDI_CMD_SIZE-1:0] cmd, input logic [3:0] ch,
                        input logic [6:0] d0, input logic [6:0] d1);
    set_cmd(cmd, ch, d0, d1);
    bus.midi_rdy = 1'b1;
    @(negedge clk);
    bus.midi_rdy = 1'b0;
  endtask

  task automatic test_reset;
    n_tests++; if (bus.midi_tx !== 1'b1)      begin n_fail++; $display("FAIL reset_tx: got %b expected 1", bus.midi_tx); end
    n_tests++; if (bus.midi_busy !== 1'b0)    begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.midi_busy); end
    n_tests++; if (bus.midi_tx_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.midi_tx_done); end
    n_tests++; if (bus.midi_drop !== 1'b0)    begin n_fail++; $display("FAIL reset_drop: got %b expected 0", bus.midi_drop); end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++; if (bus.midi_tx !== 1'b1 || bus.midi_busy !== 1'b0) begin
      n_fail++; $display("FAIL idle_after_reset: tx=%b busy=%b expected tx=1 busy=0", bus.midi_tx, bus.midi_busy);
    end
  endtask

  task automatic test_note_on;
    logic [7:0] exp [3] = '{8'h90, 8'h32, 8'h30};
    strobe(MIDI_CMD_NOTE_ON, 4'd0, 7'd50, 7'd48);
    capture(130);
    n_tests++; if (cap_busy[0] !== 1'b1 || cap_tx[0] !== 1'b0) begin
      n_fail++; $display("FAIL note_on_latency: busy=%b tx=%b expected busy=1 tx=0", cap_busy[0], cap_tx[0]);
    end
    for (int b = 0; b < 3; b++) begin
      n_tests++; if (frame_byte(b * FRAME) !== exp[b]) begin
        n_fail++; $display("FAIL note_on_byte%0d: got %h expected %h", b, frame_byte(b * FRAME), exp[b]);
      end
      n_tests++; if (!frame_ok(b * FRAME)) begin n_fail++; $display("FAIL note_on_framing%0d: start/stop bits wrong", b); end
    end
    n_tests++; if (count_hi(1, 0, 130) != 120) begin n_fail++; $display("FAIL note_on_busy: got %0d expected 120", count_hi(1, 0, 130)); end
    n_tests++; if (count_hi(2, 0, 130) != 1)   begin n_fail++; $display("FAIL note_on_done_count: got %0d expected 1", count_hi(2, 0, 130)); end
    n_tests++; if (first_hi(2, 0, 130) != 119) begin n_fail++; $display("FAIL note_on_done_cycle: got %0d expected 119", first_hi(2, 0, 130)); end
    n_tests++; if (count_hi(0, 120, 130) != 10) begin n_fail++; $display("FAIL note_on_idle_line: got %0d high expected 10", count_hi(0, 120, 130)); end
  endtask

  task automatic test_prog_change;
    strobe(MIDI_CMD_PROG_CHANGE, 4'd3, 7'd5, 7'd0);
    capture(90);
    n_tests++; if (frame_byte(0) !== 8'hC3) begin n_fail++; $display("FAIL prog_byte0: got %h expected c3", frame_byte(0)); end
    n_tests++; if (frame_byte(FRAME) !== 8'h05) begin n_fail++; $display("FAIL prog_byte1: got %h expected 05", frame_byte(FRAME)); end
    n_tests++; if (!frame_ok(0) || !frame_ok(FRAME)) begin n_fail++; $display("FAIL prog_framing: start/stop bits wrong"); end
    n_tests++; if (count_hi(1, 0, 90) != 80) begin n_fail++; $display("FAIL prog_busy: got %0d expected 80", count_hi(1, 0, 90)); end
    n_tests++; if (first_hi(2, 0, 90) != 79) begin n_fail++; $display("FAIL prog_done_cycle: got %0d expected 79", first_hi(2, 0, 90)); end
  endtask

  task automatic test_done_collision;
    logic [7:0] exp [3] = '{8'h90, 8'h01, 8'h02};
    strobe(MIDI_CMD_PROG_CHANGE, 4'd4, 7'd7, 7'd0);
    fork
      capture(210);
      begin
        repeat (79) @(negedge clk);
        set_cmd(MIDI_CMD_NOTE_ON, 4'd0, 7'd1, 7'd2);
        bus.midi_rdy = 1'b1;
        repeat (2) @(negedge clk);
        bus.midi_rdy = 1'b0;
      end
    join
    n_tests++; if (first_hi(3, 0, 210) != 80 || count_hi(3, 0, 210) != 1) begin
      n_fail++; $display("FAIL collision_drop: first=%0d count=%0d expected first=80 count=1", first_hi(3, 0, 210), count_hi(3, 0, 210));
    end
    n_tests++; if (cap_busy[80] !== 1'b0 || cap_busy[81] !== 1'b1) begin
      n_fail++; $display("FAIL collision_busy: busy80=%b busy81=%b expected 0,1", cap_busy[80], cap_busy[81]);
    end
    n_tests++; if (frame_byte(0) !== 8'hC4 || frame_byte(FRAME) !== 8'h07) begin
      n_fail++; $display("FAIL collision_first_msg: got %h %h expected c4 07", frame_byte(0), frame_byte(FRAME));
    end
    for (int b = 0; b < 3; b++) begin
      n_tests++; if (frame_byte(81 + b * FRAME) !== exp[b]) begin
        n_fail++; $display("FAIL collision_second_byte%0d: got %h expected %h", b, frame_byte(81 + b * FRAME), exp[b]);
      end
    end
    n_tests++; if (count_hi(1, 0, 210) != 200) begin n_fail++; $display("FAIL collision_busy_total: got %0d expected 200", count_hi(1, 0, 210)); end
  endtask

  task automatic test_busy_reject;
    logic [7:0] exp [3] = '{8'h91, 8'h3C, 8'h46};
    strobe(MIDI_CMD_NOTE_ON, 4'd1, 7'd60, 7'd70);
    fork
      capture(130);
      begin
        repeat (9) @(negedge clk);
        set_cmd(MIDI_CMD_NOTE_ON, 4'd2, 7'd1, 7'd2);
        bus.midi_rdy = 1'b1;
        @(negedge clk);
        bus.midi_rdy = 1'b0;
      end
    join
    n_tests++; if (count_hi(3, 0, 130) != 1 || first_hi(3, 0, 130) != 10) begin
      n_fail++; $display("FAIL reject_drop: count=%0d first=%0d expected count=1 first=10", count_hi(3, 0, 130), first_hi(3, 0, 130));
    end
    for (int b = 0; b < 3; b++) begin
      n_tests++; if (frame_byte(b * FRAME) !== exp[b]) begin
        n_fail++; $display("FAIL reject_byte%0d: got %h expected %h", b, frame_byte(b * FRAME), exp[b]);
      end
    end
    n_tests++; if (count_hi(1, 0, 130) != 120 || count_hi(2, 0, 130) != 1) begin
      n_fail++; $display("FAIL reject_busy_done: busy=%0d done=%0d expected 120,1", count_hi(1, 0, 130), count_hi(2, 0, 130));
    end
  endtask

  task automatic test_ignored;
    fork
      capture(20);
      begin
        set_cmd(MIDI_CMD_NONE, 4'd0, 7'd1, 7'd2);
        bus.midi_rdy = 1'b1;
        @(negedge clk);
        set_cmd(3'd6, 4'd5, 7'd3, 7'd4);
        @(negedge clk);
        bus.midi_rdy = 1'b0;
      end
    join
    n_tests++; if (count_hi(0, 0, 20) != 20) begin n_fail++; $display("FAIL ignored_tx: got %0d high expected 20", count_hi(0, 0, 20)); end
    n_tests++; if (count_hi(1, 0, 20) + count_hi(2, 0, 20) + count_hi(3, 0, 20) != 0) begin
      n_fail++; $display("FAIL ignored_flags: busy/done/drop pulses=%0d expected 0", count_hi(1, 0, 20) + count_hi(2, 0, 20) + count_hi(3, 0, 20));
    end
  endtask

  task automatic test_reset_midframe;
    logic [7:0] exp [3] = '{8'h90, 8'h32, 8'h30};
    strobe(MIDI_CMD_NOTE_ON, 4'd0, 7'd10, 7'd20);
    repeat (50) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_tests++; if (bus.midi_tx !== 1'b1 || bus.midi_busy !== 1'b0) begin
      n_fail++; $display("FAIL midreset_outputs: tx=%b busy=%b expected tx=1 busy=0", bus.midi_tx, bus.midi_busy);
    end
    reset = 1'b1;
    capture(20);
    n_tests++; if (count_hi(0, 0, 20) != 20 || count_hi(1, 0, 20) != 0) begin
      n_fail++; $display("FAIL midreset_abandon: tx_high=%0d busy=%0d expected 20,0", count_hi(0, 0, 20), count_hi(1, 0, 20));
    end
    strobe(MIDI_CMD_NOTE_ON, 4'd0, 7'd50, 7'd48);
    capture(130);
    for (int b = 0; b < 3; b++) begin
      n_tests++; if (frame_byte(b * FRAME) !== exp[b]) begin
        n_fail++; $display("FAIL midreset_fresh_byte%0d: got %h expected %h", b, frame_byte(b * FRAME), exp[b]);
      end
    end
    n_tests++; if (count_hi(1, 0, 130) != 120) begin n_fail++; $display("FAIL midreset_fresh_busy: got %0d expected 120", count_hi(1, 0, 130)); end
  endtask

  task automatic test_two_messages;
`ifdef MIDI_TX_RUNNING_STATUS_EN
    logic [7:0] exp [3] = '{8'h34, 8'h00, 8'hFF};
    int nb = 2;
`else
    logic [7:0] exp [3] = '{8'h90, 8'h34, 8'h00};
    int nb = 3;
`endif
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    strobe(MIDI_CMD_NOTE_ON, 4'd0, 7'd50, 7'd48);
    capture(125);
    n_tests++; if (frame_byte(0) !== 8'h90 || count_hi(1, 0, 125) != 120) begin
      n_fail++; $display("FAIL two_msg_first: status=%h busy=%0d expected 90,120", frame_byte(0), count_hi(1, 0, 125));
    end
    strobe(MIDI_CMD_NOTE_ON, 4'd0, 7'd52, 7'd0);
    capture(130);
    for (int b = 0; b < nb; b++) begin
      n_tests++; if (frame_byte(b * FRAME) !== exp[b]) begin
        n_fail++; $display("FAIL two_msg_byte%0d: got %h expected %h", b, frame_byte(b * FRAME), exp[b]);
      end
    end
    n_tests++; if (count_hi(1, 0, 130) != nb * FRAME) begin
      n_fail++; $display("FAIL two_msg_busy: got %0d expected %0d", count_hi(1, 0, 130), nb * FRAME);
    end
  endtask

  initial begin
    reset = 1'b0;
    bus.midi_rdy = 1'b0;
    set_cmd(MIDI_CMD_NONE, 4'd0, 7'd0, 7'd0);
    repeat (3) @(negedge clk);
    test_reset;
    test_note_on;
    test_prog_change;
    test_done_collision;
    test_busy_reject;
    test_ignored;
    test_reset_midframe;
    test_two_messages;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish within 1 ms");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
